control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter A, default 16, datapath width; the instruction word is A bits, and A below 16 is unsupported.
REQ-002 CLK  in  1  system clock; all state changes occur on the rising edge.
REQ-003 RST_N  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
REQ-004 IR  in  A  instruction register contents: IR[15] is the I bit, IR[14:12] the opcode, IR[11:0] the address or register-reference bits.
REQ-005 AC  in  A  accumulator value, used for skip tests.
REQ-006 E  in  1  carry/link flag from the ALU E register.
REQ-007 DR_ZERO  in  1  high when the DR value equals 0.
REQ-008 ALUOP  out  4  ALU operation code: AND=0, ADD=1, CLA=2, CMA=3, CIR=4, CIL=5, INC=6, CLE=7, CME=8, SPA=9, SNA=A, SZA=B, SZE=C, LDA=D.
REQ-009 BUS_SEL  out  3  common-bus source: 0=none, 1=AR, 2=PC, 3=DR, 4=AC, 5=IR, 7=MEM.
REQ-010 LD_AR, INR_AR, LD_PC, INR_PC, LD_DR, INR_DR, LD_AC, LD_IR  out  1 each  register load/increment strobes, acting on the next rising edge.
REQ-011 MEM_RD, MEM_WR  out  1 each  memory read/write strobes for address AR.
REQ-012 T  out  3  current timing state, 0..6.
REQ-013 HALTED  out  1  high after an HLT instruction executes.

Function
REQ-014 The sequencer shall be a state machine with states T0..T6 and HALT; any state with the last-step flag set shall return to T0 on the next edge.
REQ-015 T0: BUS_SEL=PC and LD_AR are asserted.
REQ-016 T1: MEM_RD, BUS_SEL=MEM, LD_IR and INR_PC are asserted.
REQ-017 T2: BUS_SEL=IR and LD_AR are asserted (AR takes IR[11:0]); decode is performed on IR.
REQ-018 T3, memory-reference instruction (opcode != 7) with I=1: MEM_RD, BUS_SEL=MEM and LD_AR are asserted (indirect). With I=0, T3 asserts no strobes.
REQ-019 T3, opcode=7 with I=0 (register reference): exactly one action is executed, chosen by priority B11 down to B0; lower set bits are ignored; this is the last step.
REQ-020 Register-reference mapping:
- B11 CLA, B10 CLE, B9 CMA, B8 CME, B7 CIR, B6 CIL, B5 INC each drive the matching ALUOP.
- B11, B9, B7, B6 and B5 also assert LD_AC.
- B4 SPA, B3 SNA, B2 SZA, B1 SZE drive their ALUOP and assert INR_PC only when the condition holds.
- Skip conditions: SPA when AC[15]=0; SNA when AC[15]=1; SZA when AC=0; SZE when E=0.
- B0 HLT: the next state is HALT.
- No bit set: NOP.
REQ-021 Opcode=7 with I=1 (I/O) shall be a NOP that ends at T3.
REQ-022 AND, ADD and LDA (opcodes 0, 1, 2):
- T4: MEM_RD, BUS_SEL=MEM, LD_DR.
- T5: ALUOP=AND, ADD or LDA respectively, and LD_AC; this is the last step.
REQ-023 STA (opcode 3), T4: BUS_SEL=AC and MEM_WR; this is the last step.
REQ-024 BUN (opcode 4), T4: BUS_SEL=AR and LD_PC; this is the last step.
REQ-025 BSA (opcode 5):
- T4: BUS_SEL=PC, MEM_WR, INR_AR.
- T5: BUS_SEL=AR, LD_PC; this is the last step.
REQ-026 ISZ (opcode 6):
- T4: MEM_RD, BUS_SEL=MEM, LD_DR.
- T5: INR_DR.
- T6: BUS_SEL=DR, MEM_WR, and INR_PC if DR_ZERO=1; this is the last step.
REQ-027 Strobes not listed for a state shall be 0, and ALUOP shall be 0 (AND) when unused. LD_AC is never asserted without a defined ALUOP.
REQ-028 HALT state: all strobes are 0, HALTED=1 and T=0; the state is held until reset.
REQ-029 Instruction latency:
- Register reference: 4 cycles.
- STA and BUN: 5 cycles.
- AND, ADD, LDA and BSA: 6 cycles.
- ISZ: 7 cycles.
- Indirect addressing adds no cycles.

Reset
REQ-030 While RST_N=0: the state is T0, HALTED=0, all strobes, BUS_SEL and ALUOP are 0 (output gating), and T=0.
REQ-031 The first T0 strobes shall appear in the first cycle after RST_N rises; asserting reset mid-instruction aborts it immediately with no further strobes.

Verification
REQ-032 IR=0x7800 (CLA), then IR=0x7020 (INC): T runs 0,1,2,3 per instruction; at T3, ALUOP=2 then 6, with LD_AC=1.
REQ-033 IR=0x1123 (ADD direct): T4 has MEM_RD/LD_DR; T5 has ALUOP=1 and LD_AC; 6 cycles total. IR=0x9123 additionally asserts MEM_RD/LD_AR at T3.
REQ-034 Skips:
- IR=0x7004 (SZA) with AC=0: INR_PC=1 at T3.
- Same with AC=0x0001: INR_PC=0.
- IR=0x7002 (SZE) with E=1: no skip.
REQ-035 IR=0x6050 (ISZ) with DR_ZERO=1 at T6: MEM_WR and INR_PC are asserted at T6; with DR_ZERO=0, INR_PC=0.
REQ-036 IR=0x7001 (HLT): HALTED=1 from the next cycle, and no strobes for 20 cycles. RST_N pulse low: HALTED=0 and fetch restarts at T0.
REQ-037 IR=0x7840 (CLA and CIL both set): only ALUOP=2 is issued.

Source files
------------

// File: rtl/control_sequencer.sv
// Timing-state control sequencer for a basic accumulator machine: fetches, decodes and
// steps each instruction through T0..T6, driving bus, ALU and register strobes.
module control_sequencer #(
  parameter int A = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [A-1:0] IR,
  input  logic [A-1:0] AC,
  input  logic         E,
  input  logic         DR_ZERO,
  output logic [3:0]   ALUOP,
  output logic [2:0]   BUS_SEL,
  output logic         LD_AR,
  output logic         INR_AR,
  output logic         LD_PC,
  output logic         INR_PC,
  output logic         LD_DR,
  output logic         INR_DR,
  output logic         LD_AC,
  output logic         LD_IR,
  output logic         MEM_RD,
  output logic         MEM_WR,
  output logic [2:0]   T,
  output logic         HALTED
);

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_ADD = 4'h1,
    ALU_CLA = 4'h2,
    ALU_CMA = 4'h3,
    ALU_CIR = 4'h4,
    ALU_CIL = 4'h5,
    ALU_INC = 4'h6,
    ALU_CLE = 4'h7,
    ALU_CME = 4'h8,
    ALU_SPA = 4'h9,
    ALU_SNA = 4'hA,
    ALU_SZA = 4'hB,
    ALU_SZE = 4'hC,
    ALU_LDA = 4'hD
  } aluop_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_MEM  = 3'd7
  } bus_e;

  typedef struct packed {
    aluop_e aluop;
    bus_e   bus_sel;
    logic   ld_ar;
    logic   inr_ar;
    logic   ld_pc;
    logic   inr_pc;
    logic   ld_dr;
    logic   inr_dr;
    logic   ld_ac;
    logic   ld_ir;
    logic   mem_rd;
    logic   mem_wr;
  } ctrl_t;

  typedef struct packed {
    logic        i_bit;
    logic [2:0]  opcode;
    logic [11:0] rr;
  } decode_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  state_e  state_q, state_d;
  decode_t dec_q, dec_d;
  ctrl_t   ctrl, ctrl_gated;
  logic    rr_valid;
  logic [3:0] rr_idx;

  // The instruction is captured while the sequencer sits in T2, so later steps
  // see a stable decode even if IR is disturbed.
  always_comb begin
    dec_d = dec_q;
    if (state_q == S_T2) begin
      dec_d.i_bit  = IR[15];
      dec_d.opcode = IR[14:12];
      dec_d.rr     = IR[11:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the decode register is reset too, making post-reset outputs deterministic.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_T0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
    end
  end

  // Register-reference priority: the highest set bit of IR[11:0] wins.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (dec_q.rr[i]) begin
        rr_valid = 1'b1;
        rr_idx   = 4'(i);
      end
    end
  end

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    unique case (state_q)
      S_T0: begin
        ctrl.bus_sel = BUS_PC;
        ctrl.ld_ar   = 1'b1;
        state_d      = S_T1;
      end
      S_T1: begin
        ctrl.mem_rd  = 1'b1;
        ctrl.bus_sel = BUS_MEM;
        ctrl.ld_ir   = 1'b1;
        ctrl.inr_pc  = 1'b1;
        state_d      = S_T2;
      end
      S_T2: begin
        ctrl.bus_sel = BUS_IR;
        ctrl.ld_ar   = 1'b1;
        state_d      = S_T3;
      end
      S_T3: begin
        if (dec_q.opcode == OP_REG) begin
          state_d = S_T0;
          if (!dec_q.i_bit && rr_valid) begin
            case (rr_idx)
              4'd11: begin ctrl.aluop = ALU_CLA; ctrl.ld_ac = 1'b1; end
              4'd10: ctrl.aluop = ALU_CLE;
              4'd9:  begin ctrl.aluop = ALU_CMA; ctrl.ld_ac = 1'b1; end
              4'd8:  ctrl.aluop = ALU_CME;
              4'd7:  begin ctrl.aluop = ALU_CIR; ctrl.ld_ac = 1'b1; end
              4'd6:  begin ctrl.aluop = ALU_CIL; ctrl.ld_ac = 1'b1; end
              4'd5:  begin ctrl.aluop = ALU_INC; ctrl.ld_ac = 1'b1; end
              4'd4:  begin ctrl.aluop = ALU_SPA; ctrl.inr_pc = ~AC[15]; end
              4'd3:  begin ctrl.aluop = ALU_SNA; ctrl.inr_pc = AC[15]; end
              4'd2:  begin ctrl.aluop = ALU_SZA; ctrl.inr_pc = (AC == '0); end
              4'd1:  begin ctrl.aluop = ALU_SZE; ctrl.inr_pc = ~E; end
              4'd0:  state_d = S_HALT;
              default: ;
            endcase
          end
        end else begin
          if (dec_q.i_bit) begin
            ctrl.mem_rd  = 1'b1;
            ctrl.bus_sel = BUS_MEM;
            ctrl.ld_ar   = 1'b1;
          end
          state_d = S_T4;
        end
      end
      S_T4: begin
        case (dec_q.opcode)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
            ctrl.mem_rd  = 1'b1;
            ctrl.bus_sel = BUS_MEM;
            ctrl.ld_dr   = 1'b1;
            state_d      = S_T5;
          end
          OP_STA: begin
            ctrl.bus_sel = BUS_AC;
            ctrl.mem_wr  = 1'b1;
            state_d      = S_T0;
          end
          OP_BUN: begin
            ctrl.bus_sel = BUS_AR;
            ctrl.ld_pc   = 1'b1;
            state_d      = S_T0;
          end
          OP_BSA: begin
            ctrl.bus_sel = BUS_PC;
            ctrl.mem_wr  = 1'b1;
            ctrl.inr_ar  = 1'b1;
            state_d      = S_T5;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        state_d = S_T0;
        case (dec_q.opcode)
          OP_AND: begin ctrl.aluop = ALU_AND; ctrl.ld_ac = 1'b1; end
          OP_ADD: begin ctrl.aluop = ALU_ADD; ctrl.ld_ac = 1'b1; end
          OP_LDA: begin ctrl.aluop = ALU_LDA; ctrl.ld_ac = 1'b1; end
          OP_BSA: begin
            ctrl.bus_sel = BUS_AR;
            ctrl.ld_pc   = 1'b1;
          end
          OP_ISZ: begin
            ctrl.inr_dr = 1'b1;
            state_d     = S_T6;
          end
          default: ;
        endcase
      end
      S_T6: begin
        ctrl.bus_sel = BUS_DR;
        ctrl.mem_wr  = 1'b1;
        ctrl.inr_pc  = DR_ZERO;
        state_d      = S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_T0;
    endcase
  end

  // Outputs are gated by reset so nothing leaks out while RST_N is low.
  assign ctrl_gated = RST_N ? ctrl : '0;

  assign ALUOP   = ctrl_gated.aluop;
  assign BUS_SEL = ctrl_gated.bus_sel;
  assign LD_AR   = ctrl_gated.ld_ar;
  assign INR_AR  = ctrl_gated.inr_ar;
  assign LD_PC   = ctrl_gated.ld_pc;
  assign INR_PC  = ctrl_gated.inr_pc;
  assign LD_DR   = ctrl_gated.ld_dr;
  assign INR_DR  = ctrl_gated.inr_dr;
  assign LD_AC   = ctrl_gated.ld_ac;
  assign LD_IR   = ctrl_gated.ld_ir;
  assign MEM_RD  = ctrl_gated.mem_rd;
  assign MEM_WR  = ctrl_gated.mem_wr;

  assign T      = (RST_N && state_q != S_HALT) ? 3'(state_q) : 3'd0;
  assign HALTED = RST_N && (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: steps instructions cycle by cycle and
// compares every output against hand-derived control words.
module tb_control_sequencer;

  logic        CLK;
  logic        RST_N;
  logic [15:0] IR;
  logic [15:0] AC;
  logic        E;
  logic        DR_ZERO;
  logic [3:0]  ALUOP;
  logic [2:0]  BUS_SEL;
  logic        LD_AR, INR_AR, LD_PC, INR_PC, LD_DR, INR_DR, LD_AC, LD_IR;
  logic        MEM_RD, MEM_WR;
  logic [2:0]  T;
  logic        HALTED;

  int checks = 0;
  int errors = 0;

  control_sequencer #(.A(16)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .IR      (IR),
    .AC      (AC),
    .E       (E),
    .DR_ZERO (DR_ZERO),
    .ALUOP   (ALUOP),
    .BUS_SEL (BUS_SEL),
    .LD_AR   (LD_AR),
    .INR_AR  (INR_AR),
    .LD_PC   (LD_PC),
    .INR_PC  (INR_PC),
    .LD_DR   (LD_DR),
    .INR_DR  (INR_DR),
    .LD_AC   (LD_AC),
    .LD_IR   (LD_IR),
    .MEM_RD  (MEM_RD),
    .MEM_WR  (MEM_WR),
    .T       (T),
    .HALTED  (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe mask order: LD_AR INR_AR LD_PC INR_PC LD_DR INR_DR LD_AC LD_IR MEM_RD MEM_WR
  localparam logic [9:0] M_NONE   = 10'b00_0000_0000;
  localparam logic [9:0] M_LD_AR  = 10'b10_0000_0000;
  localparam logic [9:0] M_INR_AR = 10'b01_0000_0000;
  localparam logic [9:0] M_LD_PC  = 10'b00_1000_0000;
  localparam logic [9:0] M_INR_PC = 10'b00_0100_0000;
  localparam logic [9:0] M_LD_DR  = 10'b00_0010_0000;
  localparam logic [9:0] M_INR_DR = 10'b00_0001_0000;
  localparam logic [9:0] M_LD_AC  = 10'b00_0000_1000;
  localparam logic [9:0] M_LD_IR  = 10'b00_0000_0100;
  localparam logic [9:0] M_MEM_RD = 10'b00_0000_0010;
  localparam logic [9:0] M_MEM_WR = 10'b00_0000_0001;

  logic [20:0] obs;
  assign obs = {ALUOP, BUS_SEL, LD_AR, INR_AR, LD_PC, INR_PC, LD_DR, INR_DR,
                LD_AC, LD_IR, MEM_RD, MEM_WR, T, HALTED};

  task automatic check(input string tag, input logic [20:0] observed, input logic [20:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (alu,bus,strobes,T,halted)", tag, observed, expected);
    end
  endtask

  // Compare the current cycle, then move to the next cycle's sample point.
  task automatic cyc(input string tag, input logic [3:0] alu, input logic [2:0] bus,
                     input logic [9:0] m, input logic [2:0] t, input logic h);
    check(tag, obs, {alu, bus, m, t, h});
    @(negedge CLK);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_t0"}, 4'h0, 3'd2, M_LD_AR, 3'd0, 1'b0);
    cyc({tag, "_t1"}, 4'h0, 3'd7, M_MEM_RD | M_LD_IR | M_INR_PC, 3'd1, 1'b0);
    cyc({tag, "_t2"}, 4'h0, 3'd5, M_LD_AR, 3'd2, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N   = 1'b0;
    IR      = 16'hFFFF;
    AC      = 16'h0000;
    E       = 1'b0;
    DR_ZERO = 1'b0;

    #3;
    check("reset_before_edge", obs, 21'd0);
    @(negedge CLK); #1;
    check("reset_after_edge", obs, 21'd0);

    @(negedge CLK);
    RST_N = 1'b1;
    IR    = 16'h7800;
    #1;

    // CLA then INC
    fetch("cla");
    cyc("cla_t3", 4'h2, 3'd0, M_LD_AC, 3'd3, 1'b0);
    IR = 16'h7020;
    fetch("inc");
    cyc("inc_t3", 4'h6, 3'd0, M_LD_AC, 3'd3, 1'b0);

    // ADD direct and indirect
    IR = 16'h1123;
    fetch("add");
    cyc("add_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    cyc("add_t4", 4'h0, 3'd7, M_MEM_RD | M_LD_DR, 3'd4, 1'b0);
    cyc("add_t5", 4'h1, 3'd0, M_LD_AC, 3'd5, 1'b0);
    IR = 16'h9123;
    fetch("addi");
    cyc("addi_t3", 4'h0, 3'd7, M_MEM_RD | M_LD_AR, 3'd3, 1'b0);
    cyc("addi_t4", 4'h0, 3'd7, M_MEM_RD | M_LD_DR, 3'd4, 1'b0);
    cyc("addi_t5", 4'h1, 3'd0, M_LD_AC, 3'd5, 1'b0);

    // Skips
    IR = 16'h7004; AC = 16'h0000;
    fetch("sza0");
    cyc("sza0_t3", 4'hB, 3'd0, M_INR_PC, 3'd3, 1'b0);
    AC = 16'h0001;
    fetch("sza1");
    cyc("sza1_t3", 4'hB, 3'd0, M_NONE, 3'd3, 1'b0);
    IR = 16'h7002; E = 1'b1;
    fetch("sze1");
    cyc("sze1_t3", 4'hC, 3'd0, M_NONE, 3'd3, 1'b0);
    E = 1'b0;
    fetch("sze0");
    cyc("sze0_t3", 4'hC, 3'd0, M_INR_PC, 3'd3, 1'b0);
    IR = 16'h7010; AC = 16'h8000;
    fetch("spa");
    cyc("spa_neg_t3", 4'h9, 3'd0, M_NONE, 3'd3, 1'b0);
    IR = 16'h7008;
    fetch("sna");
    cyc("sna_neg_t3", 4'hA, 3'd0, M_INR_PC, 3'd3, 1'b0);

    // ISZ with and without zero result
    IR = 16'h6050; DR_ZERO = 1'b1;
    fetch("isz1");
    cyc("isz1_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    cyc("isz1_t4", 4'h0, 3'd7, M_MEM_RD | M_LD_DR, 3'd4, 1'b0);
    cyc("isz1_t5", 4'h0, 3'd0, M_INR_DR, 3'd5, 1'b0);
    cyc("isz1_t6", 4'h0, 3'd3, M_MEM_WR | M_INR_PC, 3'd6, 1'b0);
    DR_ZERO = 1'b0;
    fetch("isz0");
    cyc("isz0_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    cyc("isz0_t4", 4'h0, 3'd7, M_MEM_RD | M_LD_DR, 3'd4, 1'b0);
    cyc("isz0_t5", 4'h0, 3'd0, M_INR_DR, 3'd5, 1'b0);
    cyc("isz0_t6", 4'h0, 3'd3, M_MEM_WR, 3'd6, 1'b0);

    // STA, BUN, BSA, LDA, AND
    IR = 16'h3010;
    fetch("sta");
    cyc("sta_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    cyc("sta_t4", 4'h0, 3'd4, M_MEM_WR, 3'd4, 1'b0);
    IR = 16'h4020;
    fetch("bun");
    cyc("bun_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    cyc("bun_t4", 4'h0, 3'd1, M_LD_PC, 3'd4, 1'b0);
    IR = 16'h5030;
    fetch("bsa");
    cyc("bsa_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    cyc("bsa_t4", 4'h0, 3'd2, M_MEM_WR | M_INR_AR, 3'd4, 1'b0);
    cyc("bsa_t5", 4'h0, 3'd1, M_LD_PC, 3'd5, 1'b0);
    IR = 16'h2040;
    fetch("lda");
    cyc("lda_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    cyc("lda_t4", 4'h0, 3'd7, M_MEM_RD | M_LD_DR, 3'd4, 1'b0);
    cyc("lda_t5", 4'hD, 3'd0, M_LD_AC, 3'd5, 1'b0);
    IR = 16'h0040;
    fetch("and");
    cyc("and_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    cyc("and_t4", 4'h0, 3'd7, M_MEM_RD | M_LD_DR, 3'd4, 1'b0);
    cyc("and_t5", 4'h0, 3'd0, M_LD_AC, 3'd5, 1'b0);

    // Priority, remaining register references, I/O NOP, plain NOP
    IR = 16'h7840;
    fetch("cla_cil");
    cyc("cla_cil_t3", 4'h2, 3'd0, M_LD_AC, 3'd3, 1'b0);
    IR = 16'h7400;
    fetch("cle");
    cyc("cle_t3", 4'h7, 3'd0, M_NONE, 3'd3, 1'b0);
    IR = 16'h7200;
    fetch("cma");
    cyc("cma_t3", 4'h3, 3'd0, M_LD_AC, 3'd3, 1'b0);
    IR = 16'h7100;
    fetch("cme");
    cyc("cme_t3", 4'h8, 3'd0, M_NONE, 3'd3, 1'b0);
    IR = 16'h7080;
    fetch("cir");
    cyc("cir_t3", 4'h4, 3'd0, M_LD_AC, 3'd3, 1'b0);
    IR = 16'h7040;
    fetch("cil");
    cyc("cil_t3", 4'h5, 3'd0, M_LD_AC, 3'd3, 1'b0);
    IR = 16'hF801;
    fetch("io");
    cyc("io_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    IR = 16'h7000;
    fetch("nop");
    cyc("nop_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);

    // Mid-instruction reset abort during ADD at T5
    IR = 16'h1123;
    fetch("abort");
    cyc("abort_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    cyc("abort_t4", 4'h0, 3'd7, M_MEM_RD | M_LD_DR, 3'd4, 1'b0);
    RST_N = 1'b0;
    #1;
    check("abort_reset_immediate", obs, 21'd0);
    @(negedge CLK); #1;
    check("abort_reset_held", obs, 21'd0);
    @(negedge CLK);
    IR    = 16'h7020;
    RST_N = 1'b1;
    #1;
    fetch("after_abort");
    cyc("after_abort_t3", 4'h6, 3'd0, M_LD_AC, 3'd3, 1'b0);

    // HLT and recovery by reset
    IR = 16'h7001;
    fetch("hlt");
    cyc("hlt_t3", 4'h0, 3'd0, M_NONE, 3'd3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("halt_%0d", i), 4'h0, 3'd0, M_NONE, 3'd0, 1'b1);
    end
    RST_N = 1'b0;
    #1;
    check("halt_reset", obs, 21'd0);
    @(negedge CLK);
    IR    = 16'h7800;
    RST_N = 1'b1;
    #1;
    fetch("restart");
    cyc("restart_t3", 4'h2, 3'd0, M_LD_AC, 3'd3, 1'b0);
    check("restart_next_t0", obs, {4'h0, 3'd2, M_LD_AR, 3'd0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
